// File: rtl/sign_restore.sv
// Re-applies stored sample signs to returning magnitudes; result registered, 1-cycle latency.
// Backpressure: s_ready drops when the sign FIFO is full, m_ready drops when it is empty.
module sign_restore #(
  parameter int DATA_WIDTH = 11,
  parameter int DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  input  logic                    m_valid,
  input  logic [DATA_WIDTH-2:0]   m_data,
  output logic                    m_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    ovf,
  output logic                    udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DEPTH-1:0]      signs;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  sign_out;
  logic [DATA_WIDTH-1:0] mag_ext;
  logic [DATA_WIDTH-1:0] result;
  logic                  unused_bits;

  // Only the MSB of each sample is kept; the rest is intentionally ignored.
  assign unused_bits = ^s_data[DATA_WIDTH-2:0];

  assign s_ready = (level != LW'(DEPTH));
  assign m_ready = (level != '0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_comb begin
    mag_ext  = {1'b0, m_data};
    sign_out = signs[rd_ptr];
    result   = mag_ext;
    if (sign_out) begin
      // Zero magnitude with a set sign encodes the most-negative value.
      if (m_data == '0)
        result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else
        result = ~mag_ext + DATA_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      signs[wr_ptr] <= s_data[DATA_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        o_data <= result;
      end
      level   <= level + LW'(push) - LW'(pop);
      o_valid <= pop;
      ovf     <= ovf | (s_valid & ~s_ready);
      udf     <= udf | (m_valid & ~m_ready);
    end
  end

endmodule
